// File: rtl/dsc_pkg.sv
// Shared types and helpers for the parallel stochastic (deterministic stream) multiplier.
package dsc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Reverse the low w bits of v; bits at and above w come back zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned w);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < w) r[i] = v[w - 1 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/dsc_sng_lanes.sv
// LANES stream-generator comparators for operand A, gated by the shared B bit, and their popcount.
module dsc_sng_lanes
    import dsc_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LANES    = 4,
    parameter bit BITREV_A = 1'b0
) (
    input  logic [WIDTH-1:0]              ca_base,
    input  logic [WIDTH-1:0]              a,
    input  logic                          sb,
    output logic [clog2(LANES + 1)-1:0]   pop
);

    logic [WIDTH-1:0] idx;
    logic [31:0]      fv;

    always_comb begin
        pop = '0;
        idx = '0;
        fv  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            idx = ca_base + WIDTH'(i);
            // Compared at 32 bits; bitrev leaves the upper bits zero so ordering is unaffected.
            fv  = BITREV_A ? bitrev(32'(idx), WIDTH) : 32'(idx);
            if (sb && (fv < 32'(a))) pop = pop + 1'b1;
        end
    end

endmodule

// File: rtl/dsc_mul_par.sv
// Unsigned multiplier built from two deterministic unary streams, LANES A-bits per cycle.
module dsc_mul_par
    import dsc_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LANES    = 4,
    parameter bit BITREV_A = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   z
);

    localparam int          N   = 1 << WIDTH;
    localparam int          ZW  = 2 * WIDTH;
    localparam int unsigned PW  = clog2(LANES + 1);
    localparam logic [WIDTH-1:0] CA_STEP = WIDTH'(LANES);
    localparam logic [WIDTH-1:0] CA_LAST = WIDTH'(N - LANES);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] ca_base;
    logic [WIDTH-1:0] cb;
    logic [ZW-1:0]    acc;
    logic [PW-1:0]    pop;
    logic             sb;
    logic             last;
    logic             zero_op;

    assign sb      = (cb < b_q);
    assign last    = (ca_base == CA_LAST) && (cb == '1);
    assign zero_op = (a == '0) || (b == '0);

    dsc_sng_lanes #(
        .WIDTH    (WIDTH),
        .LANES    (LANES),
        .BITREV_A (BITREV_A)
    ) u_lanes (
        .ca_base (ca_base),
        .a       (a_q),
        .sb      (sb),
        .pop     (pop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ca_base <= '0;
            cb      <= '0;
            acc     <= '0;
            z       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        ca_base <= '0;
                        cb      <= '0;
                        acc     <= '0;
                        // A zero operand needs no streaming: report 0 on the next edge.
                        if (zero_op) begin
                            state <= DONE;
                            z     <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    acc     <= acc + ZW'(pop);
                    ca_base <= ca_base + CA_STEP;
                    if (ca_base == CA_LAST) cb <= cb + 1'b1;
                    if (last) begin
                        state <= DONE;
                        z     <= acc + ZW'(pop);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
